// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
package uart_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // cfg_bits_i encodings
  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  // Number of data bits (5..8) selected by cfg_bits
  function automatic logic [3:0] bits_from_cfg(input logic [1:0] cfg_bits);
    return 4'd5 + {2'b00, cfg_bits};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial line synchronizer with optional 3-sample majority glitch filter.
// Optional feature macro: UART_RX_GLITCH_FILTER_EN.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic rx_i,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Metastability chain; idle-high reset so no false start after reset
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  logic [2:0] filt_q;

  // Last three synchronized samples; a single-clock pulse never wins a vote
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) filt_q <= 3'b111;
    else         filt_q <= {filt_q[1:0], sync_q[SYNC_STAGES-1]};
  end

  assign rx_s = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) | (filt_q[1] & filt_q[2]);
`else
  assign rx_s = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start/5-8 data/optional even parity/stop, valid/ready output,
// sticky error flag. Optional feature macro: UART_RX_GLITCH_FILTER_EN
// (majority filter inside uart_rx_sync).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        rx_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_en_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_bits_i,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i
);

  logic       rx_s;
  logic       rx_prev_q;

  rx_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       done_q, done_d;

  logic [3:0] nbits;
  logic [15:0] half_div;
  logic       err_set;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .rx_i   (rx_i),
    .rx_s   (rx_s)
  );

  assign nbits    = bits_from_cfg(cfg_bits_i);
  assign half_div = cfg_div_i >> 1;
  assign busy_o   = (state_q != IDLE);

  // Previous line value for start-edge detection
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rx_prev_q <= 1'b1;
    else         rx_prev_q <= rx_s;
  end

  // Frame state, baud/bit counters and shift register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  // Next-state: start bit checked mid-bit, later bits one full period apart
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cfg_en_i && rx_prev_q && !rx_s) begin
          state_d = START;
          sh_d    = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (cnt_q == half_div) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == cfg_div_i) begin
          cnt_d       = '0;
          sh_d[bit_q] = rx_s;
          if ({1'b0, bit_q} == nbits - 4'd1) state_d = cfg_parity_en_i ? PARITY : STOP;
          else                               bit_d   = bit_q + 3'd1;
        end
      end
      PARITY: begin
        if (cnt_q == cfg_div_i) begin
          cnt_d   = '0;
          perr_d  = (^sh_q) ^ rx_s;
          state_d = STOP;
        end
      end
      STOP: begin
        // Leave mid stop bit so the next start edge is not missed
        if (cnt_q == cfg_div_i) begin
          cnt_d   = '0;
          ferr_d  = !rx_s;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!cfg_en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  // Overrun: a byte lands while the previous one is still unconsumed
  assign err_set = done_q && (perr_q || ferr_q || (rx_valid_o && !rx_ready_i));

  // Output byte register and valid/ready handshake
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
    end else if (done_q) begin
      rx_data_o  <= sh_q;
      rx_valid_o <= 1'b1;
    end else if (rx_valid_o && rx_ready_i) begin
      rx_valid_o <= 1'b0;
    end
  end

  // Sticky error; a new error beats a simultaneous clear
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)        err_o <= 1'b0;
    else if (err_set)   err_o <= 1'b1;
    else if (err_clr_i) err_o <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: frame-level model plus directed checks.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rstn, rx, cfg_en, cfg_par, err_clr, rx_ready;
  logic [15:0] div;
  logic [1:0]  cfg_bits;
  logic        busy, err, rx_valid;
  logic [7:0]  rx_data;

  always #5 clk = ~clk;

  uart_rx_core dut (
    .clk_i(clk), .rstn_i(rstn), .rx_i(rx), .cfg_div_i(div), .cfg_en_i(cfg_en),
    .cfg_parity_en_i(cfg_par), .cfg_bits_i(cfg_bits), .busy_o(busy), .err_o(err),
    .err_clr_i(err_clr), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready)
  );

  int         checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  bit         model_pend = 0;
  bit         err_exp = 0;
  int         hs_cnt = 0, busy_cnt = 0, cur_nb = 8, hs0;
  logic [7:0] last_data = '0;
  logic [7:0] hi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every handshake must match the model's next byte
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (rstn && rx_valid) begin
      hi = rx_data >> cur_nb;
      chk("data_msbs_zero", 32'(hi), 32'd0);
      if (rx_ready) begin
        hs_cnt++;
        last_data  = rx_data;
        model_pend = 0;
        if (exp_q.size() == 0) chk("unexpected_byte", 32'd1, 32'd0);
        else                   chk("byte", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drive one frame; the model records what must come out and what errors it implies
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen,
                            input bit pbit, input bit stopb);
    logic [7:0] m;
    int bp;
    bp       = int'(div) + 1;
    m        = d & 8'((1 << nb) - 1);
    cfg_bits = 2'(nb - 5);
    cfg_par  = pen;
    cur_nb   = nb;
    if (pen && ((^m) ^ pbit)) err_exp = 1;
    if (!stopb) err_exp = 1;
    if (model_pend && !rx_ready) begin
      err_exp = 1;
      exp_q[exp_q.size()-1] = m;
    end else begin
      exp_q.push_back(m);
    end
    model_pend = 1;
    rx = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      repeat (bp) @(negedge clk);
    end
    if (pen) begin
      rx = pbit;
      repeat (bp) @(negedge clk);
    end
    rx = stopb;
    repeat (bp) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    err_exp = 0;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; rx = 1'b1; cfg_en = 1'b1; cfg_par = 1'b0; err_clr = 1'b0;
    rx_ready = 1'b1; div = 16'd104; cfg_bits = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // 1: 8N1 0x55 at div=104; busy spans half a bit plus nine bits
    busy_cnt = 0; hs0 = hs_cnt;
    send_frame(8'h55, 8, 0, 0, 1);
    repeat (4) @(negedge clk);
    chk("t1_count", 32'(hs_cnt - hs0), 32'd1);
    chk("t1_data", 32'(last_data), 32'h55);
    chk("t1_err", 32'(err), 32'(err_exp));
    chk("t1_busy_len", 32'(busy_cnt), 32'd998);

    // 2: back-to-back frames at div=20
    div = 16'd20; hs0 = hs_cnt;
    send_frame(8'h00, 8, 0, 0, 1);
    send_frame(8'h00, 8, 0, 0, 1);
    send_frame(8'hFF, 8, 0, 0, 1);
    repeat (4) @(negedge clk);
    chk("t2_count", 32'(hs_cnt - hs0), 32'd3);
    chk("t2_err", 32'(err), 32'(err_exp));

    // 3: even parity, good then bad
    send_frame(8'h07, 8, 1, 1, 1);
    send_frame(8'hA5, 8, 1, 0, 1);
    repeat (4) @(negedge clk);
    chk("t3_good_par_err", 32'(err), 32'(err_exp));
    send_frame(8'hA5, 8, 1, 1, 1);
    repeat (4) @(negedge clk);
    chk("t3_data", 32'(last_data), 32'hA5);
    chk("t3_par_err", 32'(err), 32'd1);
    chk("t3_par_err_model", 32'(err), 32'(err_exp));
    clear_err();
    chk("t3_err_clr", 32'(err), 32'd0);

    // 4: narrow widths, then 5-bit frame with a bad stop bit
    send_frame(8'hEA, 6, 0, 0, 1);
    send_frame(8'hDB, 7, 0, 0, 1);
    repeat (4) @(negedge clk);
    chk("t4_widths_err", 32'(err), 32'(err_exp));
    send_frame(8'h1F, 5, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("t4_data", 32'(last_data), 32'h1F);
    chk("t4_frame_err", 32'(err), 32'd1);
    clear_err();

    // 5: overrun with ready low
    rx_ready = 1'b0; hs0 = hs_cnt;
    send_frame(8'h11, 8, 0, 0, 1);
    repeat (4) @(negedge clk);
    chk("t5_valid1", 32'(rx_valid), 32'd1);
    chk("t5_data1", 32'(rx_data), 32'h11);
    chk("t5_err1", 32'(err), 32'd0);
    send_frame(8'h22, 8, 0, 0, 1);
    repeat (4) @(negedge clk);
    chk("t5_valid2", 32'(rx_valid), 32'd1);
    chk("t5_data2", 32'(rx_data), 32'h22);
    chk("t5_ovr_err", 32'(err), 32'(err_exp));
    chk("t5_ovr_err_lit", 32'(err), 32'd1);
    clear_err();
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_count", 32'(hs_cnt - hs0), 32'd1);
    chk("t5_last", 32'(last_data), 32'h22);
    chk("t5_valid_drop", 32'(rx_valid), 32'd0);

    // 6: short low pulse is a false start
    busy_cnt = 0; hs0 = hs_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_busy_len", 32'(busy_cnt), 32'd11);
    chk("t6_busy_end", 32'(busy), 32'd0);
    chk("t6_no_byte", 32'(hs_cnt - hs0), 32'd0);
`ifdef UART_RX_GLITCH_FILTER_EN
    busy_cnt = 0;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_glitch_busy", 32'(busy_cnt), 32'd0);
`endif

    // 7: disabling the receiver aborts a frame in progress
    hs0 = hs_cnt;
    rx = 1'b0;
    repeat (21 * 3) @(negedge clk);
    chk("t7_busy_mid", 32'(busy), 32'd1);
    cfg_en = 1'b0;
    @(negedge clk);
    chk("t7_abort", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    cfg_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("t7_no_byte", 32'(hs_cnt - hs0), 32'd0);

    // 8: reset mid-frame
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("t8_rst_busy", 32'(busy), 32'd0);
    chk("t8_rst_valid", 32'(rx_valid), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("model_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
